// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory fetch bus: request/ready for the address phase and rvalid for the data phase.
interface instr_fetch_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, keeps one imem fetch outstanding and hands words with their PC to decode.
// Supports decode stall through a 1-entry skid buffer, and redirect with discard of stale responses.
module instr_fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_stage_if.master imem,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                instr_valid,
    output logic [31:0]         instr,
    output logic [XLEN-1:0]     instr_pc,
    output logic [6:0]          opcode,
    output logic [2:0]          func3,
    output logic [6:0]          func7
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL, S_DROP} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] issued_pc_q, issued_pc_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic            valid_q, valid_d;
    logic            consume, out_free, req, fire;

    assign consume  = valid_q & ~stall;
    assign out_free = ~valid_q | ~stall;
    assign fire     = req & imem.imem_ready;

    always_ff @(posedge clk or negedge rst_n) begin : state_register
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            issued_pc_q  <= '0;
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            instr_pc_q   <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            issued_pc_q  <= issued_pc_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    always_comb begin : next_state_logic
        state_d      = state_q;
        pc_d         = pc_q;
        issued_pc_d  = issued_pc_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        // A consumed word is retired first; any refill below overrides it.
        if (consume) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end

        unique case (state_q)
            S_REQ: begin
                if (fire) begin
                    state_d     = S_WAIT;
                    issued_pc_d = pc_q;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    pc_d = issued_pc_q + XLEN'(4);
                    if (out_free) begin
                        valid_d    = 1'b1;
                        instr_d    = imem.imem_rdata;
                        instr_pc_d = issued_pc_q;
                        state_d    = S_REQ;
                    end else begin
                        skid_instr_d = imem.imem_rdata;
                        skid_pc_d    = issued_pc_q;
                        state_d      = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (out_free) begin
                    valid_d    = 1'b1;
                    instr_d    = skid_instr_q;
                    instr_pc_d = skid_pc_q;
                    state_d    = S_REQ;
                end
            end
            S_DROP: begin
                if (imem.imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        // Redirect overrides everything; the skid empties simply by leaving FULL.
        if (redirect_valid) begin
            pc_d    = redirect_pc & ~XLEN'(3);
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            if (state_q == S_DROP) begin
                state_d = imem.imem_rvalid ? S_REQ : S_DROP;
            end else if ((state_q == S_WAIT && !imem.imem_rvalid) || (state_q == S_REQ && fire)) begin
                state_d = S_DROP;
            end else begin
                state_d = S_REQ;
            end
        end
    end

    always_comb begin : output_logic
        req = 1'b0;
        // REQ is the reset state, so rst_n keeps the request low while reset is held.
        if (state_q == S_REQ) req = out_free & rst_n;
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q & ~XLEN'(3);

    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign opcode      = instr_q[6:0];
    assign func3       = instr_q[14:12];
    assign func7       = instr_q[31:25];
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios plus random stall/redirect/memory timing,
// checked against an in-order instruction-stream model of what decode should receive.
module tb_instr_fetch_stage;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;

    instr_fetch_stage_if #(.XLEN(32)) bus ();

    instr_fetch_stage #(
        .XLEN      (32),
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode),
        .func3          (func3),
        .func7          (func7)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus knobs
    int          p_ready   = 100;
    int          lat_max   = 0;
    int          lat_fixed = -1;
    int          p_stall   = 0;
    int          p_redir   = 0;
    bit          drv_stall = 1'b0;
    bit          drv_redir = 1'b0;
    logic [31:0] drv_rpc   = '0;
    bit          redir_on_accept = 1'b0;
    bit          redir_hit = 1'b0;
    bit          chk_rate  = 1'b0;

    // Memory responder and reference stream
    bit          pend_valid = 1'b0;
    logic [31:0] pend_addr  = '0;
    int          pend_wait  = 0;
    logic [31:0] acc_q[$];
    logic [31:0] exp_pc = RESET_PC;
    int          cyc = 0;
    int          last_cons = -1;
    int          idle = 0;
    int          n_cons = 0;
    bit          hold_chk = 1'b0;
    logic [31:0] hold_instr, hold_pc;
    bit          obs_valid = 1'b0;
    logic [31:0] obs_pc = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0008) return 32'h40B5_0533;
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        drv_stall = 1'b0;
        drv_redir = 1'b0;
        pend_valid = 1'b0;
        hold_chk = 1'b0;
        exp_pc = RESET_PC;
        last_cons = -1;
        idle = 0;
        acc_q.delete();
        #1;
        check_val("rst_valid", instr_valid, 1'b0);
        check_val("rst_instr", instr, NOP_INSTR);
        check_val("rst_pc", instr_pc, 32'h0);
        check_val("rst_req", bus.imem_req, 1'b0);
        check_val("rst_opcode", opcode, 7'h13);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step();
        logic [31:0] w;
        bit          accepted_while_pending;
        @(negedge clk);
        bus.imem_ready = ($urandom_range(0, 99) < p_ready);
        stall          = drv_stall;
        redirect_valid = drv_redir;
        redirect_pc    = drv_rpc;
        if (pend_valid && pend_wait == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend_addr);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
            if (pend_valid) pend_wait--;
        end
        #1;
        if (redir_on_accept && bus.imem_req && bus.imem_ready) begin
            redirect_valid  = 1'b1;
            redirect_pc     = drv_rpc;
            redir_on_accept = 1'b0;
            redir_hit       = 1'b1;
        end
        #3;
        // Values below are the ones the DUT registers at the coming rising edge.
        cyc++;
        obs_valid = instr_valid;
        obs_pc    = instr_pc;
        if (hold_chk) begin
            check_val("stall_hold_valid", instr_valid, 1'b1);
            check_val("stall_hold_instr", instr, hold_instr);
            check_val("stall_hold_pc", instr_pc, hold_pc);
            hold_chk = 1'b0;
        end
        if (!instr_valid) begin
            check_val("nop_instr", instr, NOP_INSTR);
            check_val("nop_opcode", opcode, 7'h13);
        end
        if (instr_valid && stall) check_val("req_while_blocked", bus.imem_req, 1'b0);
        if (pend_valid) check_val("req_while_outstanding", bus.imem_req, 1'b0);

        if (instr_valid && !stall) begin
            w = mem_word(exp_pc);
            check_val("instr_pc", instr_pc, exp_pc);
            check_val("instr", instr, w);
            check_val("opcode", opcode, w[6:0]);
            check_val("func3", func3, w[14:12]);
            check_val("func7", func7, w[31:25]);
            if (exp_pc == 32'h0000_0008) begin
                check_val("sub_opcode", opcode, 7'b0110011);
                check_val("sub_func3", func3, 3'b000);
                check_val("sub_func7", func7, 7'b0100000);
            end
            if (chk_rate && last_cons >= 0) check_val("issue_interval", cyc - last_cons, 2);
            last_cons = cyc;
            exp_pc    = exp_pc + 32'd4;
            n_cons++;
            idle = 0;
        end else if (!stall) begin
            idle++;
        end
        if (instr_valid && stall && !redirect_valid) begin
            hold_chk   = 1'b1;
            hold_instr = instr;
            hold_pc    = instr_pc;
        end

        accepted_while_pending = pend_valid && !bus.imem_rvalid;
        if (bus.imem_rvalid) pend_valid = 1'b0;
        if (bus.imem_req && bus.imem_ready) begin
            check_val("single_outstanding", accepted_while_pending, 1'b0);
            check_val("addr_align", bus.imem_addr[1:0], 2'b00);
            acc_q.push_back(bus.imem_addr);
            pend_valid = 1'b1;
            pend_addr  = bus.imem_addr;
            pend_wait  = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, lat_max);
        end
        if (redirect_valid) begin
            exp_pc   = redirect_pc & ~32'd3;
            hold_chk = 1'b0;
            idle     = 0;
        end
        if (idle > 40) begin
            check_val("progress_timeout", idle, 0);
            idle = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int mark;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        do_reset();

        // Reset asserted while a fetch is outstanding
        lat_fixed = 3;
        k = 0;
        while (!pend_valid && k < 10) begin step(); k++; end
        check_val("preReset_accept", pend_valid, 1'b1);
        do_reset();

        // Straight-line zero-wait fetch
        lat_fixed = 0;
        chk_rate  = 1'b1;
        repeat (20) step();
        chk_rate = 1'b0;
        check_val("fetch0_addr", (acc_q.size() > 0) ? acc_q[0] : 32'hDEAD_BEEF, 32'h0);
        check_val("fetch1_addr", (acc_q.size() > 1) ? acc_q[1] : 32'hDEAD_BEEF, 32'h4);
        check_val("fetch2_addr", (acc_q.size() > 2) ? acc_q[2] : 32'hDEAD_BEEF, 32'h8);
        check_val("straight_count_ok", n_cons >= 9, 1'b1);

        // Stall asserted while a fetch is in flight
        lat_fixed = 1;
        k = 0;
        while (!pend_valid && k < 10) begin step(); k++; end
        drv_stall = 1'b1;
        repeat (8) step();
        drv_stall = 1'b0;
        repeat (12) step();

        // Redirect while waiting for data
        lat_fixed = 3;
        k = 0;
        step();
        while (!(pend_valid && pend_wait > 0) && k < 10) begin step(); k++; end
        drv_redir = 1'b1;
        drv_rpc   = 32'h0000_0103;
        step();
        drv_redir = 1'b0;
        mark = acc_q.size();
        k = 0;
        step();
        while (!obs_valid && k < 30) begin step(); k++; end
        check_val("redir_wait_valid", obs_valid, 1'b1);
        check_val("redir_first_pc", obs_pc, 32'h0000_0100);
        check_val("redir_fetch_seen", acc_q.size() > mark, 1'b1);
        if (acc_q.size() > mark) check_val("redir_fetch_addr", acc_q[mark], 32'h0000_0100);

        // Redirect in the same cycle a request is accepted
        lat_fixed = 2;
        drv_rpc   = 32'h0000_2000;
        redir_hit = 1'b0;
        redir_on_accept = 1'b1;
        k = 0;
        while (!redir_hit && k < 20) begin step(); k++; end
        redir_on_accept = 1'b0;
        check_val("accept_redir_hit", redir_hit, 1'b1);
        mark = acc_q.size();
        k = 0;
        step();
        while (!obs_valid && k < 30) begin step(); k++; end
        check_val("accept_redir_valid", obs_valid, 1'b1);
        check_val("accept_redir_pc", obs_pc, 32'h0000_2000);
        check_val("accept_redir_seen", acc_q.size() > mark, 1'b1);
        if (acc_q.size() > mark) check_val("accept_redir_addr", acc_q[mark], 32'h0000_2000);

        // PC wrap at the top of the address space
        lat_fixed = 0;
        drv_redir = 1'b1;
        drv_rpc   = 32'hFFFF_FFFC;
        step();
        drv_redir = 1'b0;
        mark = acc_q.size();
        k = 0;
        while (acc_q.size() < mark + 2 && k < 40) begin step(); k++; end
        check_val("wrap_seen", acc_q.size() >= mark + 2, 1'b1);
        if (acc_q.size() >= mark + 2) begin
            check_val("wrap_addr_top", acc_q[mark], 32'hFFFF_FFFC);
            check_val("wrap_addr_zero", acc_q[mark + 1], 32'h0000_0000);
        end

        // Random stall, redirect and memory timing
        lat_fixed = -1;
        lat_max   = 3;
        p_ready   = 70;
        mark = n_cons;
        for (int i = 0; i < 2000; i++) begin
            drv_stall = ($urandom_range(0, 99) < 30);
            drv_redir = ($urandom_range(0, 99) < 4);
            drv_rpc   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            step();
        end
        drv_stall = 1'b0;
        drv_redir = 1'b0;
        repeat (10) step();
        check_val("random_progress", (n_cons - mark) > 100, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Fetch stage directly upstream of the decode/control block.
- Holds the PC and issues word fetches to instruction memory over a req/ready, rvalid handshake.
- Registers the returned instruction and presents it with its PC; opcode/func3/func7 are sliced out for the control block.
- Supports downstream stall, branch/jump redirect, and discard of in-flight fetches.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC value loaded at reset
NOP_INSTR, 32'h0000_0013, instr value while invalid (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address, word aligned
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid; exactly one per accepted request, earliest the cycle after acceptance
imem_rdata  in  32  returned instruction word
stall  in  1  decode cannot accept instr this cycle
redirect_valid  in  1  load new PC, flush fetch
redirect_pc  in  XLEN  redirect target
instr_valid  out  1  instr/instr_pc valid
instr  out  32  fetched instruction
instr_pc  out  XLEN  address of instr
opcode  out  7  instr[6:0], combinational
func3  out  3  instr[14:12], combinational
func7  out  7  instr[31:25], combinational

Behaviour:
- Reset, asynchronous while rst_n=0:
  - pc=RESET_PC, state=REQ.
  - instr_valid=0, instr=NOP_INSTR, instr_pc=0.
  - Skid buffer empty, imem_req=0.
  - First request is driven in the first clock after rst_n rises.
- Consume event: instr_valid & ~stall. The output register is "free" if ~instr_valid or consumed this cycle.
- FSM states:
  - REQ:
    - imem_req=1, imem_addr={pc[XLEN-1:2],2'b00}; held stable until imem_ready.
    - imem_ready=1 -> WAIT, issued_pc<=pc.
    - If the output is not free, hold imem_req=0 and stay in REQ.
  - WAIT:
    - imem_req=0.
    - On imem_rvalid with output free: instr<=imem_rdata, instr_pc<=issued_pc, instr_valid<=1, pc<=issued_pc+4 -> REQ.
    - On imem_rvalid with output not free: capture imem_rdata/issued_pc into the 1-entry skid buffer, pc<=issued_pc+4 -> FULL.
  - FULL:
    - imem_req=0.
    - When output free: move skid to output, instr_valid<=1, skid empty -> REQ.
  - DROP:
    - imem_req=0.
    - Wait for imem_rvalid, discard the data, then -> REQ.
- Output register:
  - If consumed and not refilled the same cycle, instr_valid<=0 and instr<=NOP_INSTR.
  - Stable while stall=1.
- Throughput: 2 cycles per instruction with zero-wait memory (REQ->WAIT->REQ); one fetch outstanding max.
- Redirect (highest priority, any state):
  - pc<=redirect_pc with bits[1:0] forced to 0.
  - instr_valid<=0, instr<=NOP_INSTR, skid cleared.
  - Next state is DROP if a response is outstanding (state WAIT without rvalid this cycle, or REQ with imem_ready this cycle); otherwise REQ.
  - Redirect during DROP only updates pc; stays DROP.
  - Redirect the same cycle as rvalid: the data is discarded, -> REQ.
- PC arithmetic: modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0.
- opcode/func3/func7 are pure slices of the instr register, so they read NOP fields while invalid.

Test Plan:
- Reset/straight-line:
  - Stimulus: assert rst_n=0 mid-WAIT, release; memory ready=1, rvalid 1 cycle later.
  - Response: instr_valid=0 during reset; fetches at 0x0,0x4,0x8; one valid instr every 2 cycles with matching instr_pc.
- Decode slices:
  - Stimulus: return 0x40B50533 (sub x10,x10,x11).
  - Response: opcode=0110011, func3=000, func7=0100000 while instr_valid=1.
- Stall/skid:
  - Stimulus: stall=1 while a fetch is in WAIT.
  - Response: the second word is captured in skid; imem_req stays 0; on stall release, instr advances in order with no loss or duplication.
- Redirect in flight:
  - Stimulus: redirect_valid with redirect_pc=0x103 while WAIT.
  - Response: the returned word is dropped; the next imem_addr is 0x100; instr_valid=0 until 0x100 data returns.
- Redirect with accept:
  - Stimulus: redirect in the same cycle as imem_ready in REQ.
  - Response: enters DROP; the stale response is discarded; the following fetch is at the redirect target.
- Wrap:
  - Stimulus: redirect to 0xFFFFFFFC.
  - Response: next fetch address is 0x00000000.
